// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states, default width.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Slice opcodes: op[2] inverts b and supplies carry-in of bit 0,
  // op[1:0] selects AND / OR / ADD / LESS.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : alu_pkg

// File: rtl/ALU1Bit.sv
// One-bit ALU slice shared with the ripple ALU: AND / OR / ADD / LESS with
// optional b inversion, plus carry, generate/propagate and raw sum (set).
module ALU1Bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       g,
  output logic       p,
  output logic       set
);

  logic b_eff;
  logic sum;

  // Bit-level datapath and result select
  always_comb begin
    b_eff  = b ^ op[2];
    sum    = a ^ b_eff ^ cin;
    cout   = (a & b_eff) | (cin & (a ^ b_eff));
    g      = a & b_eff;
    p      = a | b_eff;
    set    = sum;
    result = 1'b0;
    case (op[1:0])
      2'b00:   result = a & b_eff;
      2'b01:   result = a | b_eff;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule : ALU1Bit

// File: rtl/bit_serial_alu.sv
// Multi-cycle N-bit ALU reusing a single ALU1Bit slice, one bit per clock,
// LSB first, with a start/done handshake.
// Optional macro BIT_SERIAL_ALU_SLT_OVF_EN: SLT result becomes set XOR
// overflow (correct signed compare); otherwise SLT reports the raw sum MSB.
module bit_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             slice_result;
  logic             slice_cout;
  logic             slice_set;
  logic             slice_g_unused;
  logic             slice_p_unused;

  logic [WIDTH-1:0] res_sh_d;
  logic             ovf_d;
  logic             slt_d;
  logic [WIDTH-1:0] final_d;

  ALU1Bit u_slice (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .cin    (carry_q),
    .less   (1'b0),
    .op     (op_q),
    .result (slice_result),
    .cout   (slice_cout),
    .g      (slice_g_unused),
    .p      (slice_p_unused),
    .set    (slice_set)
  );

  // Next result shift value, MSB-bit flags and final result for the last bit
  always_comb begin
    res_sh_d = {slice_result, res_sh_q[WIDTH-1:1]};
    ovf_d    = carry_q ^ slice_cout;
`ifdef BIT_SERIAL_ALU_SLT_OVF_EN
    slt_d    = slice_set ^ ovf_d;
`else
    slt_d    = slice_set;
`endif
    final_d  = res_sh_d;
    if (op_q[1:0] == OP_SLT[1:0]) begin
      final_d = {{(WIDTH - 1){1'b0}}, slt_d};
    end
  end

  // Sequencer FSM and datapath registers; outputs are loaded on the last
  // RUN edge so they are already valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            op_q    <= op;
            carry_q <= op[2];
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          res_sh_q <= res_sh_d;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= final_d;
            cout     <= slice_cout;
            overflow <= ovf_d;
            zero     <= (final_d == '0);
            state_q  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : bit_serial_alu

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=8): arithmetic reference
// model with a per-cycle compare process, plus literal expectations.
module tb_bit_serial_alu;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic straight from the opcode definition
  task automatic model_compute(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop,
                               output logic [7:0] r, output logic c, output logic ov,
                               output logic z);
    logic [8:0] s;
    logic [7:0] be;
    logic       slt;
    be  = mop[2] ? ~mb : mb;
    s   = {1'b0, ma} + {1'b0, be} + 9'(mop[2]);
    c   = s[8];
    ov  = (ma[7] == be[7]) && (s[7] != ma[7]);
    slt = s[7];
`ifdef BIT_SERIAL_ALU_SLT_OVF_EN
    slt = slt ^ ov;
`endif
    case (mop[1:0])
      2'b00:   r = ma & be;
      2'b01:   r = ma | be;
      2'b10:   r = s[7:0];
      default: r = {7'b0, slt};
    endcase
    z = (r == 8'h00);
  endtask

  // Model timeline: phase 0 idle, 1..W busy cycles, W+1 done cycle
  int         phase = 0;
  bit         model_valid = 1'b0;
  logic [7:0] m_res = '0, p_res = '0;
  logic       m_cout = 0, m_ovf = 0, m_zero = 0;
  logic       p_cout = 0, p_ovf = 0, p_zero = 0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      m_res = '0; m_cout = 0; m_ovf = 0; m_zero = 0;
      model_valid = 1'b1;
    end else if (phase == 0) begin
      if (start) begin
        model_compute(a, b, op, p_res, p_cout, p_ovf, p_zero);
        phase = 1;
      end
    end else if (phase < int'(W)) begin
      phase++;
    end else if (phase == int'(W)) begin
      phase  = W + 1;
      m_res  = p_res; m_cout = p_cout; m_ovf = p_ovf; m_zero = p_zero;
    end else begin
      phase = 0;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy",     32'(busy),     32'(phase >= 1 && phase <= int'(W)));
      chk("done",     32'(done),     32'(phase == int'(W) + 1));
      chk("result",   32'(result),   32'(m_res));
      chk("cout",     32'(cout),     32'(m_cout));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("zero",     32'(zero),     32'(m_zero));
    end
  end

  // Start one op from IDLE and wait (bounded) for done; optionally pulse a
  // stray start and scramble inputs while busy.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [2:0] top,
                       input bit stray, output int lat);
    @(posedge clk); #1;
    a = ta; b = tbv; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (stray) begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        op = 3'($urandom);
        start = (lat == 3);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic lit_op(input string name, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic [2:0] top, input logic [7:0] er, input logic ec,
                        input logic eo, input logic ez);
    int lat;
    do_op(ta, tbv, top, 1'b0, lat);
    chk({name, "_res"},  32'(result),   32'(er));
    chk({name, "_cout"}, 32'(cout),     32'(ec));
    chk({name, "_ovf"},  32'(overflow), 32'(eo));
    chk({name, "_zero"}, 32'(zero),     32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dcount;
    int dcyc[$];
    logic [7:0] slt_exp;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 1'b0;

    // ADD with latency check
    do_op(8'h7F, 8'h01, 3'b010, 1'b0, lat);
    chk("add_latency", 32'(lat), 32'd9);
    chk("add_res",  32'(result),   32'h80);
    chk("add_cout", 32'(cout),     32'd0);
    chk("add_ovf",  32'(overflow), 32'd1);
    chk("add_zero", 32'(zero),     32'd0);

    lit_op("sub",  8'h05, 8'h05, 3'b110, 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef BIT_SERIAL_ALU_SLT_OVF_EN
    slt_exp = 8'h01;
`else
    slt_exp = 8'h00;
`endif
    lit_op("slt_ovf", 8'h80, 8'h01, 3'b111, slt_exp, 1'b1, 1'b1, slt_exp == 8'h00);
    lit_op("slt_lt",  8'h02, 8'h05, 3'b111, 8'h01, 1'b0, 1'b0, 1'b0);
    lit_op("andn", 8'hF0, 8'h3C, 3'b100, 8'hC0, 1'b1, 1'b0, 1'b0);
    lit_op("or",   8'hA0, 8'h05, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0);
    lit_op("and",  8'h0F, 8'hF0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);

    // Start re-pulsed and operands changed while busy: ignored
    do_op(8'h12, 8'h34, 3'b010, 1'b1, lat);
    chk("ignore_res", 32'(result), 32'h46);

    // start held high: back-to-back ops, one done every W+2 cycles
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; op = 3'b010; start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (done) dcyc.push_back(cyc);
    end
    start = 1'b0;
    chk("b2b_count", 32'(dcyc.size()), 32'd3);
    if (dcyc.size() == 3) begin
      chk("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd10);
      chk("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd10);
    end
    for (int i = 0; i < 40 && (busy || done); i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_idle", 32'(busy | done), 32'd0);

    // Reset in the 4th RUN cycle aborts with no done
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_result", 32'(result), 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    lit_op("after_rst", 8'h03, 8'h04, 3'b010, 8'h07, 1'b0, 1'b0, 1'b0);

    // Randomized ops, checked by the per-cycle compare process
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(8'($urandom), 8'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0), lat);
    end
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bit_serial_alu
